uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Receives 8N1 UART serial data on the board UART input (`uart_txd_in`) and delivers whole bytes over a valid/ready handshake to the downstream BPSK transmitter data path.
- It is the receiving end of the stream that `test_data` generates in simulation, and of the host serial link on hardware.
- Provides input synchronisation, false-start rejection, mid-bit majority sampling, framing-error detection, and a one-entry output holding register with overrun reporting.

Parameters:
- `CLKS_PER_BIT`, 868, `sysclk` cycles per UART bit (100 MHz / 115200); legal range 8 to 65535.
- `DATA_BITS`, 8, data bits per frame, LSB first; legal range 5 to 8.

Ports:
- `sysclk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_txd_in`  in  1  asynchronous serial line; idles high.
- `data`  out  `DATA_BITS`  received byte; stable while `valid` is high.
- `valid`  out  1  byte available in the holding register.
- `ready`  in  1  consumer accepts the byte when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- `busy`  out  1  high in any state other than IDLE.

Behaviour:
- **Reset values:** `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, bit and cycle counters=0, synchroniser flops=1. A reset mid-frame abandons the frame; the next start is detected only after reset deasserts.
- **Synchroniser:** 2-flop synchroniser on `uart_txd_in`, plus a 3-deep shift of synchronised samples used for a majority vote. All sampling uses the majority output `rxm`.
- **Cycle counter:** `cnt` counts 0..`CLKS_PER_BIT`-1, with width `$clog2(CLKS_PER_BIT)`. `MID` = `CLKS_PER_BIT`/2 (integer division).
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** on `rxm`==0, go to START with `cnt`=0.
  - **START:** at `cnt`==`MID`, sample `rxm`.
    - If `rxm`==1: false start; return to IDLE with no output.
    - If `rxm`==0: `cnt`=0, go to DATA with bit index 0.
  - **DATA:** at `cnt`==`CLKS_PER_BIT`-1, shift `rxm` into the shift register MSB (LSB-first assembly) and increment the bit index. After `DATA_BITS` bits, go to STOP.
  - **STOP:** at `cnt`==`CLKS_PER_BIT`-1, sample `rxm`.
    - If 1: byte complete; go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** remain until `rxm`==1, then go to IDLE. This prevents a break condition from retriggering.
- **Latency:** the byte-complete event occurs on the stop-bit sample cycle. `valid` and `data` update on the next rising edge. From the line start edge this is about 2+3 sync/vote cycles + (`DATA_BITS`+1.5)×`CLKS_PER_BIT`.
- **Handshake:**
  - `valid` stays high until a cycle with `ready`=1; it clears on the following edge.
  - `data` must not change while `valid`=1.
  - `ready` is ignored while `valid`=0.
- **Completion with the holding register full:** applies when a byte completes while `valid`=1 and `ready`=0.
  - Pulse `overrun` for one cycle.
  - Drop the new byte; the old byte is retained.
- **Completion on an acceptance cycle:** applies when completion coincides with `valid`=1 and `ready`=1.
  - Load the new byte and keep `valid`=1.
  - No overrun.
- **Error pulse exclusivity:** `frame_err` and `overrun` are never high in the same cycle. A frame with a bad stop bit never reaches the overrun check.
- **Idle glitches:** a line glitch shorter than 2 cycles is rejected by the vote. A low pulse shorter than `MID` is rejected at the START check.

Decomposition:
- **Package `uart_pkg`:** state enum `uart_rx_state_t` {IDLE, START, DATA, STOP, WAIT_HIGH}, default constants `UART_CLKS_PER_BIT`=868 and `UART_DATA_BITS`=8. The matching `test_data` stimulus generator also uses this package.
- **Sub-module `uart_rx_sync`:** the 2-flop synchroniser plus 3-sample majority vote. Ports: `sysclk`, `reset`, `din`, `dout`; reset output value 1.
- **Top level:** FSM, counters, shift register and output holding register remain in `uart_byte_rx`.

Test Plan:
- **Single byte:** `CLKS_PER_BIT`=16, `ready`=1, send 0xA5 → exactly one `valid` cycle with `data`=0xA5; `frame_err`=0, `overrun`=0; `busy` falls after the stop sample.
- **False start:** line low for 5 cycles (< `MID`=8), then high → `busy` rises then falls; no `valid`, no `frame_err`.
- **Framing error:** send 0x3C with the stop bit driven 0 for 2 bit times, then high → one-cycle `frame_err` pulse, no `valid`; FSM passes through WAIT_HIGH; a following 0x55 is received correctly.
- **Overrun:** `ready`=0, send 0x00 then 0xFF back-to-back → `valid`=1 with `data`=0x00 held; `overrun` pulses once at the 0xFF completion; after `ready`=1, one handshake, then `valid`=0.
- **Accept on completion:** hold `valid`=1 (byte 0x11) and assert `ready` exactly on the 0x22 completion cycle → `data`=0x22, `valid` stays 1, no `overrun`.
- **Mid-frame reset:** assert `reset` for 1 cycle during data bit 4 of 0xC3, then send 0x7E → all outputs at reset values; the only byte delivered is 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing.
// The test_data stimulus generator uses the same constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_rx_state_t;

   localparam int UART_CLKS_PER_BIT = 868;
   localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the sysclk domain.
// The output is a 2-of-3 majority over the last three synchronised samples.
module uart_rx_sync (
   input  logic sysclk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic       sync1;
   logic       sync2;
   logic [2:0] hist;

   // Everything resets to the idle (high) line level so no start is seen out of reset.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist  <= 3'b111;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         hist  <= {hist[1:0], sync2};
      end
   end

   assign dout = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with mid-bit sampling, framing-error detection and a
// one-entry valid/ready holding register that reports overruns.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a low level on the voted input
// START     | qualifying the start bit at its midpoint
// DATA      | sampling data bits one bit period apart, LSB first
// STOP      | sampling the stop bit, delivering or dropping the byte
// WAIT_HIGH | bad stop bit seen; waiting for the line to return high
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 uart_txd_in,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

   uart_rx_state_t       state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rxm;

   uart_rx_sync u_sync (
      .sysclk (sysclk),
      .reset  (reset),
      .din    (uart_txd_in),
      .dout   (rxm)
   );

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (valid && ready) valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rxm) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  cnt <= '0;
                  if (rxm) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rxm, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == BIT_LAST) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rxm) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     // A byte accepted this cycle frees the register for the new one.
                     if (!valid || ready) begin
                        data  <= shreg;
                        valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rxm) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: frame-level reference model with
// directed scenarios followed by randomized traffic and ready patterns.
module tb_uart_byte_rx;

   localparam int C      = 16;
   localparam int D      = 8;
   localparam int MID    = C / 2;
   // Edge offsets from the first edge that samples the start-bit low level.
   localparam int T_BUSY = 4;
   localparam int T_DONE = 5 + MID + (D + 1) * C;
   localparam int T_FS   = 5 + MID;
   localparam int T_BAD  = (D + 1) * C + 2 * C + 4;

   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_txd_in = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy;

   uart_byte_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .uart_txd_in (uart_txd_in),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int         t;
      logic [7:0] b;
      bit         good;
   } ev_t;

   ev_t        evq[$];
   int         busy_lo[$];
   int         busy_hi[$];
   logic [7:0] delivered[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         frame_e0 = 0;
   int         fe_seen = 0, ov_seen = 0, valid_cycles = 0;
   logic [7:0] exp_data = 8'h00;
   bit         exp_valid = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0, exp_busy = 1'b0;
   bit         was_valid;
   bit         rdone = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] last_del();
      if (delivered.size() == 0) return 8'hxx;
      return delivered[delivered.size() - 1];
   endfunction

   // Frame-level model: each scheduled frame completes at a known edge.
   always @(posedge sysclk) begin
      cyc++;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (valid && ready && !reset) delivered.push_back(data);
      if (reset) begin
         exp_valid = 1'b0;
         exp_data  = 8'h00;
         evq.delete();
         busy_lo.delete();
         busy_hi.delete();
      end else begin
         was_valid = exp_valid;
         if (exp_valid && ready) exp_valid = 1'b0;
         if (evq.size() > 0 && evq[0].t == cyc) begin
            if (!evq[0].good) exp_fe = 1'b1;
            else if (was_valid && !ready) exp_ov = 1'b1;
            else begin
               exp_data  = evq[0].b;
               exp_valid = 1'b1;
            end
            void'(evq.pop_front());
         end
      end
      while (busy_hi.size() > 0 && cyc >= busy_hi[0]) begin
         void'(busy_lo.pop_front());
         void'(busy_hi.pop_front());
      end
      exp_busy = (busy_lo.size() > 0) && (cyc >= busy_lo[0]);
   end

   always @(negedge sysclk) begin
      check("valid", valid, exp_valid);
      check("data", data, exp_data);
      check("frame_err", frame_err, exp_fe);
      check("overrun", overrun, exp_ov);
      check("busy", busy, exp_busy);
      check("err_exclusive", frame_err & overrun, 0);
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (valid) valid_cycles++;
   end

   task automatic send_frame(input logic [7:0] b, input bit bad_stop);
      ev_t e;
      @(negedge sysclk);
      frame_e0 = cyc + 1;
      e.t = frame_e0 + T_DONE;
      e.b = b;
      e.good = !bad_stop;
      evq.push_back(e);
      busy_lo.push_back(frame_e0 + T_BUSY);
      busy_hi.push_back(bad_stop ? frame_e0 + T_BAD : frame_e0 + T_DONE);
      uart_txd_in = 1'b0;
      repeat (C) @(negedge sysclk);
      for (int i = 0; i < D; i++) begin
         uart_txd_in = b[i];
         repeat (C) @(negedge sysclk);
      end
      if (bad_stop) begin
         uart_txd_in = 1'b0;
         repeat (2 * C) @(negedge sysclk);
      end
      uart_txd_in = 1'b1;
      repeat (C - 1) @(negedge sysclk);
   endtask

   initial begin
      int nd, ov0, good_cnt;
      logic [7:0] rb;
      bit bad;
      logic [7:0] c3;

      repeat (3) @(negedge sysclk);
      reset = 1'b0;
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", data, 8'h00);

      // single byte
      ready = 1'b1;
      send_frame(8'hA5, 1'b0);
      repeat (5) @(negedge sysclk);
      check("a5_count", delivered.size(), 1);
      check("a5_byte", last_del(), 8'hA5);
      check("a5_valid_cycles", valid_cycles, 1);
      check("a5_no_err", fe_seen + ov_seen, 0);

      // one-cycle glitch rejected by the vote
      @(negedge sysclk); uart_txd_in = 1'b0;
      @(negedge sysclk); uart_txd_in = 1'b1;
      repeat (12) @(negedge sysclk);

      // false start: low for 5 cycles
      @(negedge sysclk);
      frame_e0 = cyc + 1;
      busy_lo.push_back(frame_e0 + T_BUSY);
      busy_hi.push_back(frame_e0 + T_FS);
      uart_txd_in = 1'b0;
      repeat (5) @(negedge sysclk);
      uart_txd_in = 1'b1;
      repeat (30) @(negedge sysclk);
      check("fs_no_byte", delivered.size(), 1);
      check("fs_no_fe", fe_seen, 0);

      // framing error then recovery
      send_frame(8'h3C, 1'b1);
      check("fe_pulses", fe_seen, 1);
      check("fe_no_byte", delivered.size(), 1);
      send_frame(8'h55, 1'b0);
      repeat (5) @(negedge sysclk);
      check("after_fe_byte", last_del(), 8'h55);
      check("after_fe_count", delivered.size(), 2);

      // overrun
      ready = 1'b0;
      send_frame(8'h00, 1'b0);
      send_frame(8'hFF, 1'b0);
      repeat (5) @(negedge sysclk);
      check("ovr_valid", valid, 1);
      check("ovr_data", data, 8'h00);
      check("ovr_pulses", ov_seen, 1);
      ready = 1'b1;
      @(negedge sysclk); ready = 1'b0;
      @(negedge sysclk);
      check("ovr_drained", valid, 0);
      check("ovr_byte", last_del(), 8'h00);
      check("ovr_count", delivered.size(), 3);

      // accept exactly on the completion cycle
      send_frame(8'h11, 1'b0);
      repeat (5) @(negedge sysclk);
      fork
         send_frame(8'h22, 1'b0);
         begin
            @(negedge sysclk);
            #1;
            for (int i = 0; i < 400 && cyc != frame_e0 + T_DONE - 1; i++) @(negedge sysclk);
            ready = 1'b1;
            @(negedge sysclk);
            ready = 1'b0;
         end
      join
      repeat (5) @(negedge sysclk);
      check("acc_valid", valid, 1);
      check("acc_data", data, 8'h22);
      check("acc_no_ovr", ov_seen, 1);
      check("acc_prev", last_del(), 8'h11);
      ready = 1'b1;
      repeat (3) @(negedge sysclk);

      // reset during data bit 4 of 0xC3
      c3 = 8'hC3;
      @(negedge sysclk);
      frame_e0 = cyc + 1;
      busy_lo.push_back(frame_e0 + T_BUSY);
      busy_hi.push_back(frame_e0 + 100000);
      uart_txd_in = 1'b0;
      repeat (C) @(negedge sysclk);
      for (int i = 0; i < 4; i++) begin
         uart_txd_in = c3[i];
         repeat (C) @(negedge sysclk);
      end
      uart_txd_in = c3[4];
      repeat (C / 2) @(negedge sysclk);
      nd = delivered.size();
      reset = 1'b1;
      uart_txd_in = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      check("mr_valid", valid, 0);
      check("mr_data", data, 8'h00);
      check("mr_busy", busy, 0);
      check("mr_errs", {frame_err, overrun}, 0);
      repeat (2 * C) @(negedge sysclk);
      send_frame(8'h7E, 1'b0);
      repeat (5) @(negedge sysclk);
      check("mr_count", delivered.size(), nd + 1);
      check("mr_byte", last_del(), 8'h7E);

      // randomized traffic with random ready
      nd = delivered.size();
      ov0 = ov_seen;
      good_cnt = 0;
      fork
         begin
            for (int f = 0; f < 40; f++) begin
               repeat ($urandom_range(0, 20)) @(negedge sysclk);
               rb = 8'($urandom);
               bad = ($urandom_range(0, 5) == 0);
               if (!bad) good_cnt++;
               send_frame(rb, bad);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(negedge sysclk);
               ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      ready = 1'b1;
      repeat (10) @(negedge sysclk);
      check("rand_accounting", (delivered.size() - nd) + (ov_seen - ov0), good_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
